hilo_muldiv_unit: RTL

Multi-cycle multiply/divide unit with the architectural HI/LO register pair, sitting in the EX stage directly downstream of the ALU control decoder. It consumes the 5-bit ALU control code and executes the HI/LO-class operations: mult, multu, div, divu, madd, msub, mthi, mtlo, mfhi and mflo. Multiply-class operations complete in a fixed latency, and division runs as an iterative restoring divider. While an operation is in flight, the unit stalls the pipeline.

---
 rtl/hilo_muldiv_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply family, 32-step restoring divider,
// and the architectural HI/LO pair with move-to/move-from access.
module hilo_muldiv_unit #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [4:0]  alu_ctl_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DLEN  = 2 * XLEN;
    localparam int unsigned CNT_W = 5;

    localparam logic [4:0] OP_MULT  = 5'd8;
    localparam logic [4:0] OP_MULTU = 5'd9;
    localparam logic [4:0] OP_DIV   = 5'd15;
    localparam logic [4:0] OP_DIVU  = 5'd16;
    localparam logic [4:0] OP_MADD  = 5'd17;
    localparam logic [4:0] OP_MSUB  = 5'd18;
    localparam logic [4:0] OP_MFHI  = 5'd21;
    localparam logic [4:0] OP_MTHI  = 5'd22;
    localparam logic [4:0] OP_MFLO  = 5'd23;
    localparam logic [4:0] OP_MTLO  = 5'd24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    hi_q, hi_d;
    logic [XLEN-1:0]    lo_q, lo_d;
    logic [DLEN-1:0]    prod_q, prod_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    dvsr_q, dvsr_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_hilo_c;
    logic               is_sdiv_c;
    logic [XLEN-1:0]    a_abs_c;
    logic [XLEN-1:0]    b_abs_c;
    logic signed [DLEN-1:0] a_sx_c;
    logic signed [DLEN-1:0] b_sx_c;
    logic signed [DLEN-1:0] prod_s_c;
    logic [DLEN-1:0]    prod_u_c;
    logic [XLEN:0]      shifted_c;
    logic               rem_ge_c;
    logic [XLEN-1:0]    rem_sub_c;

    // Opcode classification for stall qualification.
    always_comb begin
        is_hilo_c = 1'b0;
        case (alu_ctl_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB,
            OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO: is_hilo_c = 1'b1;
            default:                            is_hilo_c = 1'b0;
        endcase
    end

    // Full 64-bit signed and unsigned products of the current operands.
    assign a_sx_c   = {{XLEN{a_i[XLEN-1]}}, a_i};
    assign b_sx_c   = {{XLEN{b_i[XLEN-1]}}, b_i};
    assign prod_s_c = a_sx_c * b_sx_c;
    assign prod_u_c = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};

    assign is_sdiv_c = (alu_ctl_i == OP_DIV);
    assign a_abs_c   = a_i[XLEN-1] ? (~a_i + XLEN'(1)) : a_i;
    assign b_abs_c   = b_i[XLEN-1] ? (~b_i + XLEN'(1)) : b_i;

    // One restoring step: the partial remainder stays below the divisor, so 33 bits suffice.
    assign shifted_c = {rem_q, quo_q[XLEN-1]};
    assign rem_ge_c  = (shifted_c >= {1'b0, dvsr_q});
    assign rem_sub_c = shifted_c[XLEN-1:0] - dvsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    case (alu_ctl_i)
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            // madd/msub fold in HI/LO as seen at accept time.
                            case (alu_ctl_i)
                                OP_MULT:  prod_d = prod_s_c;
                                OP_MULTU: prod_d = prod_u_c;
                                OP_MADD:  prod_d = {hi_q, lo_q} + prod_s_c;
                                default:  prod_d = {hi_q, lo_q} - prod_s_c;
                            endcase
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_i == '0) begin
                                quo_d   = '1;
                                rem_d   = a_i;
                                q_neg_d = 1'b0;
                                r_neg_d = 1'b0;
                                state_d = S_FIX;
                            end else begin
                                quo_d   = is_sdiv_c ? a_abs_c : a_i;
                                dvsr_d  = is_sdiv_c ? b_abs_c : b_i;
                                rem_d   = '0;
                                q_neg_d = is_sdiv_c & (a_i[XLEN-1] ^ b_i[XLEN-1]);
                                r_neg_d = is_sdiv_c & a_i[XLEN-1];
                                cnt_d   = CNT_W'(XLEN - 1);
                                state_d = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod_q;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                rem_d = rem_ge_c ? rem_sub_c : shifted_c[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], rem_ge_c};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                // Two's-complement negation also yields 0x80000000 for the overflow case.
                lo_d    = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
                hi_d    = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign result_o = (alu_ctl_i == OP_MFHI) ? hi_q :
                      (alu_ctl_i == OP_MFLO) ? lo_q : '0;
    assign stall_o  = start_i & busy_q & is_hilo_c;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule
